// File: rtl/vga_sram_arbiter.sv
// rtl/vga_sram_arbiter.sv - SRAM arbiter: priority VGA reads, posted writes via FIFO
module vga_sram_arbiter #(
    parameter int AW       = 20,
    parameter int DW       = 16,
    parameter int WF_DEPTH = 4,
    parameter int WF_LW    = 3
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iRD_REQ,
    input  logic [AW-1:0]    iRD_ADDR,
    output logic [DW-1:0]    oRD_DATA,
    output logic             oRD_VALID,
    input  logic             iWR_VALID,
    output logic             oWR_READY,
    input  logic [AW-1:0]    iWR_ADDR,
    input  logic [DW-1:0]    iWR_DATA,
    input  logic [1:0]       iWR_BE,
    output logic [WF_LW-1:0] oWF_LEVEL,
    output logic [AW-1:0]    oSRAM_ADDR,
    inout  wire  [DW-1:0]    ioSRAM_DQ,
    output logic             oSRAM_CE_N,
    output logic             oSRAM_OE_N,
    output logic             oSRAM_WE_N,
    output logic             oSRAM_UB_N,
    output logic             oSRAM_LB_N
);

    localparam int PW = $clog2(WF_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    localparam logic [PW-1:0]    PTR_ONE    = 1;
    localparam logic [WF_LW-1:0] LVL_ONE    = 1;
    localparam logic [WF_LW-1:0] LVL_ZERO   = 0;
    localparam logic [WF_LW-1:0] LVL_FULL   = WF_LW'(WF_DEPTH);

    // Posted-write storage; contents need no reset because level gates every read of it.
    logic [AW-1:0] wf_addr [WF_DEPTH];
    logic [DW-1:0] wf_data [WF_DEPTH];
    logic [1:0]    wf_be   [WF_DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WF_LW-1:0] level;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          push;
    logic          pop;
    logic [DW-1:0] dq_out;
    logic          dq_oe;

    assign oWR_READY = (level != LVL_FULL);
    assign oWF_LEVEL = level;
    assign push      = iWR_VALID & oWR_READY;
    assign pop       = (state_nxt == ST_WRITE);

    // DQ is driven by us only while a write bus cycle is on the pins.
    assign ioSRAM_DQ = dq_oe ? dq_out : {DW{1'bz}};

    // Next bus cycle: reads always win; a write needs an entry already resident in the FIFO.
    always_comb begin
        state_nxt = ST_IDLE;
        if (iRD_REQ) begin
            state_nxt = ST_READ;
        end else if (level != LVL_ZERO) begin
            state_nxt = ST_WRITE;
        end
    end

    // Capture a pushed word into the slot at the write pointer.
    always_ff @(posedge iCLK) begin
        if (push) begin
            wf_addr[wr_ptr] <= iWR_ADDR;
            wf_data[wr_ptr] <= iWR_DATA;
            wf_be[wr_ptr]   <= iWR_BE;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Registered SRAM pins for the bus cycle chosen at this edge.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= ST_IDLE;
            oSRAM_ADDR <= '0;
            oSRAM_CE_N <= 1'b1;
            oSRAM_OE_N <= 1'b1;
            oSRAM_WE_N <= 1'b1;
            oSRAM_UB_N <= 1'b1;
            oSRAM_LB_N <= 1'b1;
            dq_out     <= '0;
            dq_oe      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state_nxt)
                ST_READ: begin
                    oSRAM_ADDR <= iRD_ADDR;
                    oSRAM_CE_N <= 1'b0;
                    oSRAM_OE_N <= 1'b0;
                    oSRAM_WE_N <= 1'b1;
                    oSRAM_UB_N <= 1'b0;
                    oSRAM_LB_N <= 1'b0;
                    dq_oe      <= 1'b0;
                end
                ST_WRITE: begin
                    oSRAM_ADDR <= wf_addr[rd_ptr];
                    dq_out     <= wf_data[rd_ptr];
                    oSRAM_CE_N <= 1'b0;
                    oSRAM_OE_N <= 1'b1;
                    oSRAM_WE_N <= 1'b0;
                    oSRAM_UB_N <= ~wf_be[rd_ptr][1];
                    oSRAM_LB_N <= ~wf_be[rd_ptr][0];
                    dq_oe      <= 1'b1;
                end
                default: begin
                    oSRAM_CE_N <= 1'b1;
                    oSRAM_OE_N <= 1'b1;
                    oSRAM_WE_N <= 1'b1;
                    oSRAM_UB_N <= 1'b1;
                    oSRAM_LB_N <= 1'b1;
                    dq_oe      <= 1'b0;
                end
            endcase
        end
    end

    // Sample SRAM data at the end of each read bus cycle and flag it for one cycle.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oRD_DATA  <= '0;
            oRD_VALID <= 1'b0;
        end else begin
            oRD_VALID <= (state == ST_READ);
            if (state == ST_READ) begin
                oRD_DATA <= ioSRAM_DQ;
            end
        end
    end

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// tb/tb_vga_sram_arbiter.sv - scoreboard bench for vga_sram_arbiter with async SRAM model
module tb_vga_sram_arbiter;

    logic        iCLK;
    logic        iRST_n;
    logic        iRD_REQ;
    logic [19:0] iRD_ADDR;
    logic [15:0] oRD_DATA;
    logic        oRD_VALID;
    logic        iWR_VALID;
    logic        oWR_READY;
    logic [19:0] iWR_ADDR;
    logic [15:0] iWR_DATA;
    logic [1:0]  iWR_BE;
    logic [2:0]  oWF_LEVEL;
    logic [19:0] oSRAM_ADDR;
    wire  [15:0] ioSRAM_DQ;
    logic        oSRAM_CE_N;
    logic        oSRAM_OE_N;
    logic        oSRAM_WE_N;
    logic        oSRAM_UB_N;
    logic        oSRAM_LB_N;

    int checks = 0;
    int errors = 0;

    logic [15:0] sram_mem [0:4095];
    logic [15:0] rd_q [$];
    logic [19:0] wa_q [$];
    logic [15:0] wd_q [$];
    logic [1:0]  wb_q [$];
    logic [15:0] rd_exp_now;
    int          we_low_count = 0;
    int          cur_run = 0;
    int          max_run = 0;
    int          we_base;

    vga_sram_arbiter #(.AW(20), .DW(16), .WF_DEPTH(4), .WF_LW(3)) dut (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .iRD_REQ    (iRD_REQ),
        .iRD_ADDR   (iRD_ADDR),
        .oRD_DATA   (oRD_DATA),
        .oRD_VALID  (oRD_VALID),
        .iWR_VALID  (iWR_VALID),
        .oWR_READY  (oWR_READY),
        .iWR_ADDR   (iWR_ADDR),
        .iWR_DATA   (iWR_DATA),
        .iWR_BE     (iWR_BE),
        .oWF_LEVEL  (oWF_LEVEL),
        .oSRAM_ADDR (oSRAM_ADDR),
        .ioSRAM_DQ  (ioSRAM_DQ),
        .oSRAM_CE_N (oSRAM_CE_N),
        .oSRAM_OE_N (oSRAM_OE_N),
        .oSRAM_WE_N (oSRAM_WE_N),
        .oSRAM_UB_N (oSRAM_UB_N),
        .oSRAM_LB_N (oSRAM_LB_N)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Asynchronous SRAM read side: drives DQ whenever chip and output are enabled.
    assign ioSRAM_DQ = (!oSRAM_CE_N && !oSRAM_OE_N && oSRAM_WE_N) ?
                       sram_mem[oSRAM_ADDR[11:0]] : 16'hzzzz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        if (iRD_REQ) rd_q.push_back(rd_exp_now);
        @(posedge iCLK);
        #1;
    endtask

    task automatic exp_write(input logic [19:0] a, input logic [15:0] d, input logic [1:0] b);
        wa_q.push_back(a);
        wd_q.push_back(d);
        wb_q.push_back(b);
    endtask

    // Monitor: compares read results and write bus cycles against the queues, commits writes.
    always @(negedge iCLK) begin
        if (iRST_n) begin
            if (oRD_VALID) begin
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 32'(oRD_DATA), 32'hFFFF_FFFF);
                end else begin
                    check("rd_data", 32'(oRD_DATA), 32'(rd_q.pop_front()));
                end
            end else begin
                cur_run = 0;
            end
            if (!oSRAM_WE_N) begin
                we_low_count++;
                if (wa_q.size() == 0) begin
                    check("wr_unexpected", 32'(oSRAM_ADDR), 32'hFFFF_FFFF);
                end else begin
                    check("wr_addr", 32'(oSRAM_ADDR), 32'(wa_q.pop_front()));
                    check("wr_data", 32'(ioSRAM_DQ), 32'(wd_q.pop_front()));
                    check("wr_be", 32'({~oSRAM_UB_N, ~oSRAM_LB_N, oSRAM_CE_N, oSRAM_OE_N}),
                          32'({wb_q.pop_front(), 1'b0, 1'b1}));
                end
                if (!oSRAM_CE_N) begin
                    if (!oSRAM_LB_N) sram_mem[oSRAM_ADDR[11:0]][7:0]  = ioSRAM_DQ[7:0];
                    if (!oSRAM_UB_N) sram_mem[oSRAM_ADDR[11:0]][15:8] = ioSRAM_DQ[15:8];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) sram_mem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) sram_mem[i] = 16'(i * 3);
        sram_mem[12'h010] = 16'hBEEF;
        sram_mem[12'h020] = 16'h1111;
        sram_mem[12'h345] = 16'h1234;
        iRST_n = 1'b0; iRD_REQ = 1'b0; iRD_ADDR = '0; rd_exp_now = '0;
        iWR_VALID = 1'b0; iWR_ADDR = '0; iWR_DATA = '0; iWR_BE = '0;
        repeat (2) @(posedge iCLK);
        #1;
        check("rst_ctrl", 32'({oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, oSRAM_UB_N, oSRAM_LB_N}), 32'h1F);
        check("rst_addr", 32'(oSRAM_ADDR), 32'h0);
        check("rst_dq_oe", 32'(dut.dq_oe), 32'h0);
        check("rst_rd", 32'({oRD_VALID, oRD_DATA}), 32'h0);
        check("rst_level", 32'(oWF_LEVEL), 32'h0);
        check("rst_ready", 32'(oWR_READY), 32'h1);
        iRST_n = 1'b1;
        tick();

        // single read
        iRD_REQ = 1'b1; iRD_ADDR = 20'h00010; rd_exp_now = 16'hBEEF;
        tick();
        iRD_REQ = 1'b0;
        check("t1_oe_low", 32'(oSRAM_OE_N), 32'h0);
        check("t1_valid_early", 32'(oRD_VALID), 32'h0);
        tick();
        check("t1_valid", 32'(oRD_VALID), 32'h1);
        check("t1_data", 32'(oRD_DATA), 32'hBEEF);
        tick(); tick();

        // back-to-back reads
        we_base = we_low_count; max_run = 0;
        for (int i = 0; i < 8; i++) begin
            iRD_REQ = 1'b1; iRD_ADDR = 20'(i); rd_exp_now = 16'(i * 3);
            tick();
        end
        iRD_REQ = 1'b0;
        repeat (3) tick();
        check("t2_run", 32'(max_run), 32'd8);
        check("t2_we_high", 32'(we_low_count - we_base), 32'd0);

        // fill FIFO under continuous reads, then drain
        iRD_REQ = 1'b1; iRD_ADDR = 20'h00020; rd_exp_now = 16'h1111;
        for (int k = 0; k < 5; k++) begin
            iWR_VALID = 1'b1; iWR_ADDR = 20'h00100 + 20'(k); iWR_DATA = 16'hC000 + 16'(k); iWR_BE = 2'b11;
            check("t3_ready", 32'(oWR_READY), (k < 4) ? 32'h1 : 32'h0);
            if (k < 4) exp_write(iWR_ADDR, iWR_DATA, 2'b11);
            tick();
        end
        iWR_VALID = 1'b0;
        check("t3_level_full", 32'(oWF_LEVEL), 32'd4);
        check("t3_ready_full", 32'(oWR_READY), 32'h0);
        we_base = we_low_count;
        iRD_REQ = 1'b0;
        repeat (4) tick();
        check("t3_level_empty", 32'(oWF_LEVEL), 32'd0);
        tick();
        check("t3_we_pulses", 32'(we_low_count - we_base), 32'd4);

        // full FIFO draining while the writer keeps offering
        iRD_REQ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iWR_VALID = 1'b1; iWR_ADDR = 20'h00200 + 20'(k); iWR_DATA = 16'hD000 + 16'(k); iWR_BE = 2'b11;
            exp_write(iWR_ADDR, iWR_DATA, 2'b11);
            tick();
        end
        iRD_REQ = 1'b0; iWR_ADDR = 20'h00204; iWR_DATA = 16'hD004;
        check("t4_ready_full", 32'(oWR_READY), 32'h0);
        tick();
        check("t4_level_pop", 32'(oWF_LEVEL), 32'd3);
        check("t4_ready_again", 32'(oWR_READY), 32'h1);
        exp_write(20'h00204, 16'hD004, 2'b11);
        tick();
        check("t4_level_pushpop", 32'(oWF_LEVEL), 32'd3);
        iWR_VALID = 1'b0;
        repeat (3) tick();
        check("t4_level_empty", 32'(oWF_LEVEL), 32'd0);
        tick(); tick();

        // lower-byte-only write then readback
        iWR_VALID = 1'b1; iWR_ADDR = 20'h12345; iWR_DATA = 16'hA55A; iWR_BE = 2'b01;
        exp_write(20'h12345, 16'hA55A, 2'b01);
        tick();
        iWR_VALID = 1'b0;
        check("t5_level_one", 32'(oWF_LEVEL), 32'd1);
        check("t5_no_same_cycle_drain", 32'(oSRAM_WE_N), 32'h1);
        tick();
        check("t5_we_lb_ub", 32'({oSRAM_WE_N, oSRAM_UB_N, oSRAM_LB_N}), 32'b010);
        tick();
        iRD_REQ = 1'b1; iRD_ADDR = 20'h12345; rd_exp_now = 16'h125A;
        tick();
        iRD_REQ = 1'b0;
        tick();
        check("t5_readback", 32'(oRD_DATA), 32'h125A);
        tick();

        // reset in the middle of a drain
        iRD_REQ = 1'b1; iRD_ADDR = 20'h00020; rd_exp_now = 16'h1111;
        for (int k = 0; k < 3; k++) begin
            iWR_VALID = 1'b1; iWR_ADDR = 20'h00300 + 20'(k); iWR_DATA = 16'hE000 + 16'(k); iWR_BE = 2'b11;
            if (k == 0) exp_write(iWR_ADDR, iWR_DATA, 2'b11);
            tick();
        end
        iWR_VALID = 1'b0; iRD_REQ = 1'b0;
        tick();
        @(negedge iCLK);
        #2;
        iRST_n = 1'b0;
        #1;
        check("t6_ctrl_idle", 32'({oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, oSRAM_UB_N, oSRAM_LB_N}), 32'h1F);
        check("t6_dq_released", 32'(dut.dq_oe), 32'h0);
        check("t6_level", 32'(oWF_LEVEL), 32'd0);
        check("t6_ready", 32'(oWR_READY), 32'h1);
        we_base = we_low_count;
        repeat (2) @(posedge iCLK);
        #1;
        iRST_n = 1'b1;
        repeat (6) tick();
        check("t6_no_we_after_reset", 32'(we_low_count - we_base), 32'd0);
        check("t6_level_after", 32'(oWF_LEVEL), 32'd0);

        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("wr_q_drained", 32'(wa_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
